integer_muldiv_execute: RTL

Parametrised RV32M/RV64M multiply–divide execute unit. It sits beside the integer ALU on the integer issue port and takes one M-extension instruction at a time from the integer issue queue. Multiplies run through a MUL_STAGES-deep pipeline; divides and remainders run on an iterative radix-2 restoring divider with fast paths for special cases. The result is held under a valid/ready handshake to the shared writeback/broadcast arbiter, and the whole unit is squashable by a pipeline flush.

---
 rtl/integer_muldiv_execute.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/integer_muldiv_execute.sv
// RV32M/RV64M multiply/divide execute unit: multi-cycle multiply, radix-2 restoring divide,
// single op in flight, result held under valid/ready until the writeback arbiter takes it.
module integer_muldiv_execute #(
  parameter int XLEN         = 32,
  parameter int ROB_ID_WIDTH = 4,
  parameter int MUL_STAGES   = 2
) (
  input  logic                    clk,
  input  logic                    rst_aL,
  input  logic                    flush,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [XLEN-1:0]         src1,
  input  logic [XLEN-1:0]         src2,
  input  logic [2:0]              funct3,
  input  logic [ROB_ID_WIDTH-1:0] rob_id_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         result,
  output logic [ROB_ID_WIDTH-1:0] rob_id_out
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_n;

  logic [CW-1:0]           cnt;
  logic [XLEN-1:0]         a_q, b_q, rem_q, quot_q, dvs_q;
  logic [2:0]              f3_q;
  logic [ROB_ID_WIDTH-1:0] rob_q;
  logic                    neg_q, neg_r;
  logic [XLEN-1:0]         result_q;
  logic [ROB_ID_WIDTH-1:0] rob_out_q;

  // MULH/MULHSU sign-extend src1, only MULH sign-extends src2; low half is sign-agnostic.
  function automatic logic [XLEN-1:0] mul_res(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                              input logic [2:0] f);
    logic [2*XLEN-1:0] ae, be, p;
    ae = {{XLEN{(f[1] ^ f[0]) & a[XLEN-1]}}, a};
    be = {{XLEN{(f[1:0] == 2'b01) & b[XLEN-1]}}, b};
    p  = ae * be;
    return (f[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  logic            accept, div_zero, div_ovf, a_neg, b_neg, special;
  logic [XLEN-1:0] special_res;
  logic [XLEN:0]   rs, diff;
  logic [XLEN-1:0] rem_n, quot_n, q_fix, r_fix, div_res;

  assign issue_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_valid   = (state == DONE);
  assign result      = result_q;
  assign rob_id_out  = rob_out_q;

  always_comb begin
    accept      = issue_valid & issue_ready & ~flush;
    a_neg       = ~funct3[0] & src1[XLEN-1];
    b_neg       = ~funct3[0] & src2[XLEN-1];
    div_zero    = (src2 == '0);
    div_ovf     = ~funct3[0] & (src1 == {1'b1, {(XLEN-1){1'b0}}}) & (&src2);
    special     = funct3[2] & (div_zero | div_ovf);
    special_res = div_zero ? (funct3[1] ? src1 : '1) : (funct3[1] ? '0 : src1);
    // One restoring step: shift next dividend bit into the partial remainder, trial-subtract.
    rs      = {rem_q, quot_q[XLEN-1]};
    diff    = rs - {1'b0, dvs_q};
    rem_n   = diff[XLEN] ? rs[XLEN-1:0] : diff[XLEN-1:0];
    quot_n  = {quot_q[XLEN-2:0], ~diff[XLEN]};
    q_fix   = neg_q ? -quot_n : quot_n;
    r_fix   = neg_r ? -rem_n : rem_n;
    div_res = f3_q[1] ? r_fix : q_fix;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = !funct3[2] ? ((MUL_STAGES == 1) ? DONE : MUL) : (special ? DONE : DIV);
      MUL:  if (cnt <= CW'(1)) state_n = DONE;
      DIV:  if (cnt == '0) state_n = DONE;
      DONE: if (out_ready) state_n = !accept ? IDLE :
                             !funct3[2] ? ((MUL_STAGES == 1) ? DONE : MUL) : (special ? DONE : DIV);
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      state     <= IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      dvs_q     <= '0;
      f3_q      <= '0;
      rob_q     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      result_q  <= '0;
      rob_out_q <= '0;
    end else begin
      state <= state_n;
      if (flush) begin
        cnt <= '0;
      end else if (accept) begin
        a_q    <= src1;
        b_q    <= src2;
        f3_q   <= funct3;
        rob_q  <= rob_id_in;
        cnt    <= funct3[2] ? CW'(XLEN-1) : CW'(MUL_STAGES-1);
        rem_q  <= '0;
        quot_q <= a_neg ? -src1 : src1;
        dvs_q  <= b_neg ? -src2 : src2;
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        // Ops that complete at the accept edge (specials, single-stage multiply) load the result now.
        if (state_n == DONE) begin
          result_q  <= funct3[2] ? special_res : mul_res(src1, src2, funct3);
          rob_out_q <= rob_id_in;
        end
      end else begin
        case (state)
          MUL: begin
            cnt <= (cnt == '0) ? '0 : cnt - CW'(1);
            if (state_n == DONE) begin
              result_q  <= mul_res(a_q, b_q, f3_q);
              rob_out_q <= rob_q;
            end
          end
          DIV: begin
            cnt    <= (cnt == '0) ? '0 : cnt - CW'(1);
            rem_q  <= rem_n;
            quot_q <= quot_n;
            if (cnt == '0) begin
              result_q  <= div_res;
              rob_out_q <= rob_q;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
